// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the bitstream counter.
//   state_e : controller states (IDLE, ACCUM, HOLD)
//   cnt_w() : number of bits needed to hold a count of 0..n
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bitstream_counter_ones_accumulator.sv
// Per-neuron ones counter.
//   clk, n_rst : clock, async active-low reset
//   clr        : zero the count (wins over en)
//   en         : add bit_in this cycle
//   bit_in     : bitstream sample for this neuron
//   acc        : running count of ones
module ones_accumulator #(
    parameter int COUNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   bit_in,
    output logic [COUNT_WIDTH-1:0] acc
);

    logic [COUNT_WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr)     acc_d = '0;
        else if (en) acc_d = acc_q + COUNT_WIDTH'(bit_in);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/bitstream_counter.sv
// Converts NEURON_COUNT stochastic bitstreams into ones counts over a window
// of WINDOW_LEN valid samples; results leave on a valid/ready interface.
//   clk, n_rst   : clock, async active-low reset
//   start        : begin a window (from IDLE, or on the HOLD handshake)
//   stream_in    : one sample bit per neuron
//   stream_valid : stream_in is a sample this cycle
//   counts       : registered per-neuron count of the last completed window
//   out_valid    : counts holds an unconsumed result
//   out_ready    : consumer accepts counts
//   busy         : accumulating a window
// Build option BITSTREAM_COUNTER_CONTINUOUS_EN: windows run back to back
// after the first start, counts becomes a one-deep buffer, and the sticky
// overrun output flags a result overwritten before it was consumed.
module bitstream_counter
    import bitstream_pkg::*;
#(
    parameter int NEURON_COUNT = 2,
    parameter int WINDOW_LEN   = 256,
    parameter int COUNT_WIDTH  = cnt_w(WINDOW_LEN)
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic                                     start,
    input  logic [NEURON_COUNT-1:0]                  stream_in,
    input  logic                                     stream_valid,
    output logic [NEURON_COUNT-1:0][COUNT_WIDTH-1:0] counts,
    output logic                                     out_valid,
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
    output logic                                     overrun,
`endif
    input  logic                                     out_ready,
    output logic                                     busy
);

    state_e                                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]                   smp_q, smp_d;
    logic [NEURON_COUNT-1:0][COUNT_WIDTH-1:0] counts_q, counts_d;
    logic                                     out_valid_q, out_valid_d;
    logic [NEURON_COUNT-1:0][COUNT_WIDTH-1:0] acc;
    logic                                     acc_clr, acc_en;
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
    logic                                     overrun_q, overrun_d;
`endif

    // The sample counter only reaches WINDOW_LEN-1 before wrapping, so the
    // count width is always enough.
    localparam logic [COUNT_WIDTH-1:0] LAST_SMP = COUNT_WIDTH'(WINDOW_LEN - 1);

    always_comb begin
        state_d     = state_q;
        smp_d       = smp_q;
        counts_d    = counts_q;
        out_valid_d = out_valid_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
        overrun_d   = overrun_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    smp_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            ACCUM: begin
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
                // Consumer handshake first; a same-cycle completion below
                // re-asserts out_valid with the fresh result.
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
`endif
                if (stream_valid) begin
                    if (smp_q == LAST_SMP) begin
                        // Final sample is folded straight into the result.
                        for (int i = 0; i < NEURON_COUNT; i++)
                            counts_d[i] = acc[i] + COUNT_WIDTH'(stream_in[i]);
                        out_valid_d = 1'b1;
                        smp_d       = '0;
                        acc_clr     = 1'b1;
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
                        if (out_valid_q && !out_ready) overrun_d = 1'b1;
`else
                        state_d     = HOLD;
`endif
                    end else begin
                        smp_d  = smp_q + 1'b1;
                        acc_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        state_d = ACCUM;
                        smp_d   = '0;
                        acc_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            smp_q       <= '0;
            counts_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            counts_q    <= counts_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end
    assign overrun = overrun_q;
`endif

    for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_acc
        ones_accumulator #(.COUNT_WIDTH(COUNT_WIDTH)) u_acc (
            .clk    (clk),
            .n_rst  (n_rst),
            .clr    (acc_clr),
            .en     (acc_en),
            .bit_in (stream_in[g]),
            .acc    (acc[g])
        );
    end

    assign counts    = counts_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_bitstream_counter.sv
module tb_bitstream_counter;

    localparam int NC = 2;
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
    localparam int WL = 4;
`else
    localparam int WL = 8;
`endif
    localparam int CW = $clog2(WL + 1);

    logic                   clk = 1'b0;
    logic                   n_rst;
    logic                   start;
    logic [NC-1:0]          stream_in;
    logic                   stream_valid;
    logic [NC-1:0][CW-1:0]  counts;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
    logic                   overrun;
`endif

    int total = 0;
    int bad   = 0;

    bitstream_counter #(.NEURON_COUNT(NC), .WINDOW_LEN(WL)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .stream_in    (stream_in),
        .stream_valid (stream_valid),
        .counts       (counts),
        .out_valid    (out_valid),
`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
        .overrun      (overrun),
`endif
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one window of WL valid samples (p0/p1 bit k is sample k).
    // gaps: valid only on odd cycles. rdy_last: raise out_ready on the
    // final sample edge only. chk_pre: out_valid must stay low until done.
    task automatic accum(input logic [WL-1:0] p0, input logic [WL-1:0] p1,
                         input bit gaps, input bit rdy_last, input bit chk_pre,
                         output int cyc);
        int idx;
        idx = 0;
        cyc = 0;
        while (idx < WL && cyc < 4 * WL + 8) begin
            bit v;
            v = gaps ? (cyc % 2 == 1) : 1'b1;
            stream_valid = v;
            stream_in    = v ? {p1[idx], p0[idx]} : NC'($urandom);
            out_ready    = rdy_last && v && (idx == WL - 1);
            tick();
            cyc++;
            if (v) idx++;
            if (chk_pre && idx < WL) chk("pre_valid", out_valid, 0);
        end
        stream_valid = 1'b0;
        out_ready    = 1'b0;
        chk("win_done", idx, WL);
    endtask

    task automatic chk_counts(input string tag, input logic [WL-1:0] p0, input logic [WL-1:0] p1);
        chk({tag, "_c0"}, counts[0], $countones(p0));
        chk({tag, "_c1"}, counts[1], $countones(p1));
    endtask

    task automatic hs(input bit st);
        out_ready = 1'b1;
        start     = st;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("hs_valid", out_valid, 0);
        chk("hs_busy", busy, st);
    endtask

    initial begin
        logic [WL-1:0] a0, a1, b0, b1, c0, c1;
        int cyc;

        n_rst = 1'b0; start = 1'b1; stream_valid = 1'b1; stream_in = '1; out_ready = 1'b0;
        #2;
        chk("rst_counts", counts, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        repeat (3) tick();
        chk("rst_hold_counts", counts, 0);
        chk("rst_hold_busy", busy, 0);
        n_rst = 1'b1; start = 1'b0;

        for (int k = 0; k < 10; k++) begin
            stream_valid = 1'($urandom);
            stream_in    = NC'($urandom);
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_valid", out_valid, 0);
        end
        stream_valid = 1'b0;

`ifdef BITSTREAM_COUNTER_CONTINUOUS_EN
        start = 1'b1; tick(); start = 1'b0;
        chk("c_busy", busy, 1);
        a0 = WL'($urandom); a1 = WL'($urandom);
        accum(a0, a1, 1'($urandom), 1'b0, 1'b1, cyc);
        chk("c_a_valid", out_valid, 1);
        chk("c_a_ovr", overrun, 0);
        chk("c_a_busy", busy, 1);
        chk_counts("c_a", a0, a1);
        // handshake lands on the completing edge: result kept, no overrun
        b0 = WL'($urandom); b1 = WL'($urandom);
        accum(b0, b1, 1'b0, 1'b1, 1'b0, cyc);
        chk("c_b_valid", out_valid, 1);
        chk("c_b_ovr", overrun, 0);
        chk_counts("c_b", b0, b1);
        // nobody consumes b: c overwrites it and flags overrun
        c0 = WL'($urandom); c1 = '1;
        accum(c0, c1, 1'($urandom), 1'b0, 1'b0, cyc);
        chk("c_c_valid", out_valid, 1);
        chk("c_c_ovr", overrun, 1);
        chk_counts("c_c", c0, c1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("c_hs_valid", out_valid, 0);
        chk("c_hs_ovr", overrun, 1);
        chk_counts("c_hs", c0, c1);
        repeat (5) tick();
        chk("c_sticky_ovr", overrun, 1);
        n_rst = 1'b0; #2;
        chk("c_rst_ovr", overrun, 0);
        chk("c_rst_busy", busy, 0);
        n_rst = 1'b1;
`else
        // directed pattern: neuron0 10101010, neuron1 all ones
        a0 = 8'b01010101; a1 = 8'hFF;
        start = 1'b1; tick(); start = 1'b0;
        chk("w1_busy", busy, 1);
        accum(a0, a1, 1'b0, 1'b0, 1'b1, cyc);
        chk("w1_cyc", cyc, WL);
        chk("w1_valid", out_valid, 1);
        chk("w1_busy_done", busy, 0);
        chk_counts("w1", a0, a1);
        hs(1'b0);
        chk_counts("w1_retain", a0, a1);

        // same data with gaps: twice the cycles, same counts
        start = 1'b1; tick(); start = 1'b0;
        accum(a0, a1, 1'b1, 1'b0, 1'b1, cyc);
        chk("w2_cyc", cyc, 2 * WL);
        chk("w2_valid", out_valid, 1);
        chk_counts("w2", a0, a1);

        // HOLD ignores streams until out_ready
        for (int k = 0; k < 10; k++) begin
            stream_valid = 1'($urandom);
            stream_in    = NC'($urandom);
            start        = 1'($urandom);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_busy", busy, 0);
            chk_counts("hold", a0, a1);
        end
        stream_valid = 1'b0;
        hs(1'b1);

        // chained random windows, handshake+start each time
        for (int w = 0; w < 5; w++) begin
            if (w == 0)      begin b0 = '1; b1 = '1; end
            else if (w == 1) begin b0 = '0; b1 = '0; end
            else             begin b0 = WL'($urandom); b1 = WL'($urandom); end
            accum(b0, b1, 1'($urandom), 1'b0, 1'b1, cyc);
            chk("rw_valid", out_valid, 1);
            chk_counts("rw", b0, b1);
            hs(1'b1);
        end

        // abort mid-window with reset
        for (int k = 0; k < 5; k++) begin
            stream_valid = 1'b1; stream_in = '1;
            tick();
            chk("abort_pre", out_valid, 0);
        end
        n_rst = 1'b0; #2;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_counts", counts, 0);
        n_rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            stream_valid = 1'b1; stream_in = NC'($urandom);
            tick();
            chk("abort_idle", out_valid, 0);
        end
        stream_valid = 1'b0;
        c0 = '0; c1 = '0;
        start = 1'b1; tick(); start = 1'b0;
        accum(c0, c1, 1'b0, 1'b0, 1'b1, cyc);
        chk("z_valid", out_valid, 1);
        chk_counts("z", c0, c1);
        hs(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitstream_counter.md
Name: bitstream_counter

Overview:
Downstream consumer of a neuron layer's bitstream outputs. It converts each neuron's stochastic bitstream to a binary count of ones over a fixed window of WINDOW_LEN valid samples. The finished count vector is presented on a valid/ready output interface to the next binary stage, for example an argmax or a host readback.

Parameters:
NEURON_COUNT, 2, number of parallel bitstreams (one per neuron)
WINDOW_LEN, 256, valid samples per conversion window (>=1)
COUNT_WIDTH, $clog2(WINDOW_LEN+1), width of each count (derived; do not override)

Ports:
clk  input  1  single clock, rising edge
n_rst  input  1  asynchronous, active-low reset
start  input  1  begin a conversion window (single-cycle pulse or level)
stream_in  input  NEURON_COUNT  one bitstream bit per neuron; bit i is neuron i
stream_valid  input  1  stream_in is a sample this cycle
counts  output  NEURON_COUNT x COUNT_WIDTH  registered count of ones per neuron
out_valid  output  1  counts holds a completed window
out_ready  input  1  consumer accepts counts
busy  output  1  high while in ACCUM

Behaviour:
- Reset (async, n_rst low): state=IDLE; all accumulators, the sample counter, counts, out_valid and busy = 0. Asserting reset mid-window aborts the window; no partial result is produced.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 -> ACCUM next cycle, with accumulators and sample counter cleared on that edge.
  - stream_valid is ignored in IDLE.
- ACCUM, each cycle with stream_valid=1:
  - sample counter += 1.
  - acc[i] += stream_in[i].
  - stream_valid=0 holds all state.
  - start is ignored.
- Window completion:
  - The edge that accepts the WINDOW_LEN-th valid sample loads counts[i] = acc[i] + stream_in[i] (the final sample is included).
  - The same edge sets out_valid=1 and moves to HOLD.
  - Latency: out_valid rises on the clock edge of the last sample.
- HOLD: counts and out_valid stay stable until out_ready=1.
  - out_valid && out_ready: out_valid=0 next cycle.
  - Next state on that handshake is ACCUM if start=1 in the same cycle (accumulators cleared), otherwise IDLE.
- counts retains its last value after the handshake until the next completion.
- Arithmetic: counts never exceed WINDOW_LEN. An all-ones stream gives exactly WINDOW_LEN; an all-zeros stream gives 0.
- WINDOW_LEN=1: a single valid sample completes the window.
- busy = (state==ACCUM).

Optional Feature:
Macro: BITSTREAM_COUNTER_CONTINUOUS_EN
- Defined:
  - After completion, the block returns to ACCUM immediately with cleared accumulators; no start is needed after the first one.
  - counts acts as an output buffer. If a new window completes while out_valid=1 and !out_ready, the new result overwrites counts and the extra output port overrun (1 bit, sticky) is set.
  - overrun is cleared only by reset.
  - A completion in the same cycle as a handshake loads the new counts, keeps out_valid=1, and does not set overrun.
- Undefined: behaviour exactly as above; no overrun port.

Decomposition:
- Package bitstream_pkg:
  - state enum typedef (IDLE, ACCUM, HOLD).
  - count-width helper function for $clog2(N+1).
- Sub-module ones_accumulator: one per-neuron counter with clear, enable and bit inputs, COUNT_WIDTH wide. Instantiated NEURON_COUNT times in a generate loop; the FSM and sample counter stay in the top module.

Test Plan:
- Reset with start and stream_valid held high -> counts=0, out_valid=0, busy=0. Release reset with no start -> remains IDLE indefinitely.
- WINDOW_LEN=8, NEURON_COUNT=2, start, 8 valid samples: neuron0 stream 10101010, neuron1 stream 11111111 -> counts={8,4} (neuron1 high). out_valid rises on the 8th sample edge.
- Same window with stream_valid low on alternating cycles -> identical counts. Completion occurs after 16 cycles, not 8.
- out_ready held low for 10 cycles in HOLD -> counts and out_valid stable, and stream changes are ignored. Then out_ready=1 with start=1 -> next window begins with counts starting from 0.
- Reset pulse after 5 of 8 samples -> out_valid never rises. After restart with all-zero streams -> counts={0,0}.
- BITSTREAM_COUNTER_CONTINUOUS_EN, WINDOW_LEN=4, out_ready=0 over 2 windows -> overrun=1 and counts hold the second window's values. Then out_ready=1 -> out_valid drops; overrun stays 1 until reset.
